// File: rtl/serial_sum_deserializer.sv
// Collects an LSB-first serial bit stream (qualified by vld, ended by last) into a W-bit word.
// Define SERIAL_DESER_SIGN_EXTEND_EN to sign-extend short, non-overflowing words instead of zero-filling.
module serial_sum_deserializer #(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld,
  input  logic                   bit_in,
  input  logic                   last,
  output logic                   out_vld,
  output logic [W-1:0]           out_data,
  output logic [$clog2(W+1)-1:0] out_len,
  output logic                   overflow
);

  localparam int LW = $clog2(W+1);

  logic [W-1:0]  buf_reg, buf_next;
  logic [LW-1:0] cnt_reg, cnt_next;
  logic          ovf_reg, ovf_next;
  logic          full, store, done;
  logic [W-1:0]  store_bit;
  logic [W-1:0]  word;

  assign full  = (cnt_reg == LW'(W));
  assign store = vld && !full;
  assign done  = vld && last;

  // One-hot write strobe: only the bit addressed by the counter is updated.
  for (genvar gi = 0; gi < W; gi++) begin : g_store
    assign store_bit[gi] = store && (cnt_reg == LW'(gi));
  end

  always_comb begin
    buf_next = (buf_reg & ~store_bit) | (store_bit & {W{bit_in}});
    cnt_next = store ? cnt_reg + LW'(1) : cnt_reg;
    ovf_next = ovf_reg | (vld && full);
  end

`ifdef SERIAL_DESER_SIGN_EXTEND_EN
  logic [W-1:0] msb_sel;
  logic [W-1:0] upper;
  logic         msb;
  logic         extend;

  // Unwritten positions are already zero, so OR-ing in the upper mask sign-extends.
  for (genvar gi = 0; gi < W; gi++) begin : g_sext
    assign msb_sel[gi] = (cnt_next == LW'(gi + 1)) && buf_next[gi];
    assign upper[gi]   = (cnt_next <= LW'(gi));
  end

  assign msb    = |msb_sel;
  assign extend = msb && (cnt_next != '0) && (cnt_next != LW'(W)) && !ovf_next;
  assign word   = extend ? (buf_next | upper) : buf_next;
`else
  assign word = buf_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg  <= '0;
      cnt_reg  <= '0;
      ovf_reg  <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      out_len  <= '0;
      overflow <= 1'b0;
    end else begin
      out_vld <= done;
      if (done) begin
        out_data <= word;
        out_len  <= cnt_next;
        overflow <= ovf_next;
        buf_reg  <= '0;
        cnt_reg  <= '0;
        ovf_reg  <= 1'b0;
      end else begin
        buf_reg <= buf_next;
        cnt_reg <= cnt_next;
        ovf_reg <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Self-checking bench for serial_sum_deserializer (W=8): vector table plus reset corner sequences.
module tb_serial_sum_deserializer;

  localparam int W = 8;
`ifdef SERIAL_DESER_SIGN_EXTEND_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic         bit_in;
  logic         last;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic [3:0]   out_len;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         len;
    bit         ovf;
  } exp_t;

  typedef struct {
    int          n;
    logic [15:0] bits;
    bit          gap;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  vec_t tbl[9];

  serial_sum_deserializer #(.W(W)) dut (
    .clk(clk), .rst(rst), .vld(vld), .bit_in(bit_in), .last(last),
    .out_vld(out_vld), .out_data(out_data), .out_len(out_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed pulse must match the oldest outstanding word.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=1 required=0 data=%0h t=%0t", out_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'(out_data), int'(e.data));
        chk("out_len", int'(out_len), e.len);
        chk("overflow", int'(overflow), int'(e.ovf));
        $display("word data=%02h len=%0d ovf=%0b", out_data, out_len, overflow);
      end
    end
  end

  task automatic cyc(input logic r, input logic v, input logic b, input logic l);
    rst = r; vld = v; bit_in = b; last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t t);
    for (int i = 0; i < t.n; i++) begin
      if (t.gap && i > 0) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      if (i == t.n - 1) begin
        sb.push_back(t.e);
        last_exp = t.e;
      end
      cyc(1'b0, 1'b1, t.bits[i], i == t.n - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4,  16'h000D, 1'b0, '{SE ? 8'hFD : 8'h0D, 4, 1'b0}};
    tbl[1] = '{3,  16'h0003, 1'b1, '{8'h03, 3, 1'b0}};
    tbl[2] = '{1,  16'h0001, 1'b0, '{SE ? 8'hFF : 8'h01, 1, 1'b0}};
    tbl[3] = '{2,  16'h0002, 1'b0, '{SE ? 8'hFE : 8'h02, 2, 1'b0}};
    tbl[4] = '{10, 16'h03FF, 1'b0, '{8'hFF, 8, 1'b1}};
    tbl[5] = '{2,  16'h0001, 1'b0, '{8'h01, 2, 1'b0}};
    tbl[6] = '{8,  16'h005A, 1'b1, '{8'h5A, 8, 1'b0}};
    tbl[7] = '{9,  16'h01A5, 1'b0, '{8'hA5, 8, 1'b1}};
    tbl[8] = '{7,  16'h0035, 1'b1, '{8'h35, 7, 1'b0}};

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_len", int'(out_len), 0);
    chk("rst_overflow", int'(overflow), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 9; k++) send(tbl[k]);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hold_data", int'(out_data), int'(last_exp.data));
    chk("hold_len", int'(out_len), last_exp.len);

    // Partial word discarded by reset mid-stream.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send('{1, 16'h0000, 1'b0, '{8'h00, 1, 1'b0}});
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset wins over a simultaneous vld&last; the following word starts clean.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_last_data", int'(out_data), 0);
    chk("rst_last_len", int'(out_len), 0);
    send('{2, 16'h0002, 1'b0, '{SE ? 8'hFE : 8'h02, 2, 1'b0}});
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    chk("pending_words", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
